// File: rtl/dm_dump_sequencer.sv
// Streams every data-memory word out over valid/ready on a dump request and
// counts processor store cycles while idle.
module dm_dump_sequencer #(
    parameter int N     = 64,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = 16
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          dump,
    input  logic          DM_writeEnable,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_addr,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] write_count,
    output logic          wr_during_dump
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic          dump_q;
    logic          start;
    logic          load;
    logic          last;
    logic [N-1:0]  addr_n;

    assign start = dump & ~dump_q;
    assign last  = (idx == AW'(DEPTH - 1));

    always_comb begin
        addr_n           = '0;
        addr_n[AW+2:0]   = {idx, 3'b000};
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    state_n = S_REQ;
                end
            end
            S_REQ:  state_n = S_WAIT;
            S_WAIT: begin
                load    = 1'b1;
                state_n = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx + AW'(1);
                        state_n = S_REQ;
                    end
                end
            end
            S_DONE: begin
                if (!dump) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            dump_q    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            dump_q    <= dump;
            rd_addr   <= idx_n;
            busy      <= (state_n == S_REQ) || (state_n == S_WAIT) || (state_n == S_OUT);
            done      <= (state_n == S_DONE);
            out_valid <= (state_n == S_OUT);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_addr <= '0;
        end else if (load) begin
            out_data <= rd_data;
            out_addr <= addr_n;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            write_count    <= '0;
            wr_during_dump <= 1'b0;
        end else begin
            if (DM_writeEnable && (state == S_IDLE) && (write_count != '1))
                write_count <= write_count + CW'(1);
            if (DM_writeEnable && busy)
                wr_during_dump <= 1'b1;
        end
    end

endmodule

// File: doc/dm_dump_sequencer.md
Name: dm_dump_sequencer

Overview:
- Sits downstream of processor_arm's data-memory port.
- On a dump request it walks every data-memory word in order through a synchronous read port and streams each word out on a valid/ready interface. The bench or host logger consumes that stream.
- It also counts store cycles (DM_writeEnable) issued while the processor runs, so the bench can check store activity against the dump.

Parameters:
- N, 64, data word width and byte-address width.
- DEPTH, 32, number of data-memory words dumped (power of two, ≥2).
- AW, $clog2(DEPTH), word-index width for the memory read port.
- CW, 16, width of the store counter.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dump  in  1  dump request, level; a dump starts on its rising edge.
- DM_writeEnable  in  1  processor store strobe, counted.
- rd_addr  out  AW  word index to the data-memory read port.
- rd_data  in  N  read data, valid one cycle after rd_addr is sampled.
- out_valid  out  1  out_addr/out_data hold a dumped word.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  N  byte address of the dumped word (index·8).
- out_data  out  N  dumped word.
- busy  out  1  dump in progress.
- done  out  1  dump complete.
- write_count  out  CW  saturating count of store cycles.
- wr_during_dump  out  1  sticky flag: a store was seen while busy.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - state=IDLE, idx=0, dump_q=0.
  - rd_addr=0, out_valid=0, out_addr=0, out_data=0.
  - busy=0, done=0, write_count=0, wr_during_dump=0.
  - Reset mid-dump aborts immediately, and no further words are emitted.
- dump_q registers dump every cycle. start = dump & ~dump_q.
- rd_addr = idx (registered) in all states.
- States:
  - IDLE: busy=0, done=0. If start, set idx=0 and go to REQ.
  - REQ: busy=1. Memory samples rd_addr at this cycle's closing edge. Go to WAIT.
  - WAIT: busy=1. rd_data is valid. Latch out_data=rd_data and out_addr={idx,3'b000} zero-extended to N. Go to OUT.
  - OUT: busy=1, out_valid=1. out_data/out_addr stay stable until the handshake.
    - out_ready=0: stay in OUT.
    - out_ready=1 and idx==DEPTH-1: out_valid drops next cycle; go to DONE.
    - out_ready=1 otherwise: idx++ and go to REQ.
  - DONE: busy=0, done=1. When dump=0, go to IDLE (done clears the same edge). A dump held high never restarts.
- Throughput: one word per 3 cycles when out_ready is held at 1. The first out_valid is asserted 3 cycles after the start edge (REQ, WAIT, OUT).
- Words are emitted exactly once each, in index order 0..DEPTH-1. No word is skipped or duplicated under any out_ready pattern.
- A start edge seen while not in IDLE is ignored.
- write_count:
  - Increments on each cycle with DM_writeEnable=1 while state==IDLE.
  - Saturates at 2^CW−1 (no wrap).
  - Holds in all other states; cleared only by reset.
- wr_during_dump is set on any DM_writeEnable=1 while busy=1. It is cleared only by reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset during activity: assert reset with DM_writeEnable=1 mid-cycle → all outputs 0 immediately (before the next edge); write_count stays 0 while reset is held.
- Full dump, always ready: preload mem[i]=0x1000+i for DEPTH=32, pulse dump, out_ready=1 → 32 words, out_addr=0x00,0x08..0xF8, data 0x1000..0x101F. First out_valid 3 cycles after the edge; done asserted 96 cycles after the edge; busy=0 in DONE.
- Backpressure: toggle out_ready 1,0,0,1… → every word is held stable while out_valid=1&&!out_ready; exactly 32 handshakes with no repeats; checksum of data equals 0x1000·32+496.
- Store counting: 10 cycles of DM_writeEnable in IDLE → write_count=10. With CW=4, 20 cycles → write_count=15 (saturated). Stores during a dump leave the count unchanged and set wr_during_dump=1.
- Dump level handling: hold dump=1 through DONE → no restart and done stays 1. Drop dump, then re-pulse → IDLE, then a second full dump of 32 words. A second rising edge mid-dump is ignored.
- Reset mid-dump: assert reset while in OUT at idx=5 → out_valid=0, busy=0, idx=0 asynchronously. After release, a new dump starts from word 0.
